// File: rtl/shift_result_serializer_pkg.sv
// Shared types and constants for the shift result serializer.
// Opcode tags, field widths and the FIFO entry layout.
`timescale 1ns/1ps
package shift_pkg;

    localparam int TAG_W  = 3;
    localparam int DATA_W = 8;

    localparam int ENTRY_W = TAG_W + DATA_W;

    localparam logic [TAG_W-1:0] OP_PASS = 3'd0;
    localparam logic [TAG_W-1:0] OP_SLL  = 3'd1;
    localparam logic [TAG_W-1:0] OP_SRL  = 3'd2;
    localparam logic [TAG_W-1:0] OP_SLA  = 3'd3;
    localparam logic [TAG_W-1:0] OP_SRA  = 3'd4;
    localparam logic [TAG_W-1:0] OP_ROL  = 3'd5;
    localparam logic [TAG_W-1:0] OP_ROR  = 3'd6;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } fifo_entry_t;

    // Even parity: XOR of every tag and data bit.
    function automatic logic even_parity(
        input fifo_entry_t e
    );
        return ^e;
    endfunction

endpackage

// File: rtl/shift_result_serializer_if.sv
// Handshake bundle between the shift unit, the serializer
// and the serial sink.
`timescale 1ns/1ps
interface shift_result_serializer_if #(
    parameter int DEPTH = 4
);
    import shift_pkg::*;

    logic                   in_valid;
    logic                   in_ready;
    logic [DATA_W-1:0]      in_data;
    logic [TAG_W-1:0]       in_opcode;
    logic                   ser_out;
    logic                   ser_valid;
    logic                   ser_ready;
    logic                   ser_first;
    logic                   ser_last;
    logic [$clog2(DEPTH):0] fifo_count;

    // Producer / sink side.
    modport master (
        output in_valid,
        output in_data,
        output in_opcode,
        output ser_ready,
        input  in_ready,
        input  ser_out,
        input  ser_valid,
        input  ser_first,
        input  ser_last,
        input  fifo_count
    );

    // Serializer side.
    modport slave (
        input  in_valid,
        input  in_data,
        input  in_opcode,
        input  ser_ready,
        output in_ready,
        output ser_out,
        output ser_valid,
        output ser_first,
        output ser_last,
        output fifo_count
    );

endinterface

// File: rtl/shift_result_serializer_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers.
// Count, full and empty come from registered pointers only.
`timescale 1ns/1ps
module sync_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [WIDTH-1:0]       wdata_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      wr_ptr_d;
    logic [AW:0]      rd_ptr_q;
    logic [AW:0]      rd_ptr_d;

    // Pointer advance on push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // Pointer registers; reset empties the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write; contents need no reset.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign full_o  = (count_o == DEPTH_C);
    assign empty_o = (count_o == '0);

endmodule

// File: rtl/shift_result_serializer.sv
// Buffers tagged shift results and emits each one as a
// framed serial bitstream: tag, data, optional even parity.
`timescale 1ns/1ps
module shift_result_serializer
    import shift_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int MSB_FIRST = 1,
    parameter int PARITY_EN = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    shift_result_serializer_if.slave bus
);

    localparam int FRAME_MAX = TAG_W + DATA_W + 1;
    localparam int FLEN =
        TAG_W + DATA_W + ((PARITY_EN != 0) ? 1 : 0);
    localparam int CNT_W = $clog2(FRAME_MAX);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FLEN - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e                 state_q;
    state_e                 state_d;
    logic [FLEN-1:0]        sreg_q;
    logic [FLEN-1:0]        sreg_d;
    logic [CNT_W-1:0]       bitcnt_q;
    logic [CNT_W-1:0]       bitcnt_d;

    logic                   push;
    logic                   pop;
    logic                   full;
    logic                   empty;
    logic [ENTRY_W-1:0]     rdata;
    logic [$clog2(DEPTH):0] count;

    fifo_entry_t            wentry;
    fifo_entry_t            head;
    logic [TAG_W-1:0]       tag_ord;
    logic [DATA_W-1:0]      data_ord;
    logic [FRAME_MAX-1:0]   frame_full;
    logic [FLEN-1:0]        frame_w;

    assign wentry.tag  = bus.in_opcode;
    assign wentry.data = bus.in_data;
    assign push        = bus.in_valid & ~full;

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wentry),
        .rdata_o (rdata),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    assign head = fifo_entry_t'(rdata);

    // Order each field so the bit to send next sits at the top.
    always_comb begin
        tag_ord  = '0;
        data_ord = '0;
        for (int i = 0; i < TAG_W; i++) begin
            tag_ord[i] = (MSB_FIRST != 0)
                       ? head.tag[i]
                       : head.tag[TAG_W-1-i];
        end
        for (int i = 0; i < DATA_W; i++) begin
            data_ord[i] = (MSB_FIRST != 0)
                        ? head.data[i]
                        : head.data[DATA_W-1-i];
        end
    end

    // Parity sits in the lowest slot and drops off when disabled.
    assign frame_full = {tag_ord, data_ord, even_parity(head)};
    assign frame_w    = frame_full[FRAME_MAX-1 -: FLEN];

    // Next state: load on pop, shift on each accepted bit.
    always_comb begin
        state_d  = state_q;
        sreg_d   = sreg_q;
        bitcnt_d = bitcnt_q;
        pop      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop      = 1'b1;
                    sreg_d   = frame_w;
                    bitcnt_d = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.ser_ready) begin
                    if (bitcnt_q == LAST_IDX) begin
                        if (!empty) begin
                            pop      = 1'b1;
                            sreg_d   = frame_w;
                            bitcnt_d = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        sreg_d   = sreg_q << 1;
                        bitcnt_d = bitcnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, shift register and bit counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            sreg_q   <= '0;
            bitcnt_q <= '0;
        end else begin
            state_q  <= state_d;
            sreg_q   <= sreg_d;
            bitcnt_q <= bitcnt_d;
        end
    end

    assign bus.ser_valid  = (state_q == SHIFT);
    assign bus.ser_out    = bus.ser_valid & sreg_q[FLEN-1];
    assign bus.ser_first  = bus.ser_valid
                          & (bitcnt_q == '0);
    assign bus.ser_last   = bus.ser_valid
                          & (bitcnt_q == LAST_IDX);
    assign bus.in_ready   = ~full;
    assign bus.fifo_count = count;

endmodule

// File: tb/tb_shift_result_serializer.sv
// Scoreboard bench for shift_result_serializer: MSB-first
// with parity, plus an LSB-first no-parity variant.
`timescale 1ns/1ps
module tb_shift_result_serializer;
    import shift_pkg::*;

    logic clk;
    logic rst;

    int checks;
    int errors;

    fifo_entry_t sbq[$];

    shift_result_serializer_if #(.DEPTH(4)) ia ();
    shift_result_serializer_if #(.DEPTH(4)) ib ();

    shift_result_serializer #(
        .DEPTH     (4),
        .MSB_FIRST (1),
        .PARITY_EN (1)
    ) u_a (
        .clk (clk),
        .rst (rst),
        .bus (ia.slave)
    );

    shift_result_serializer #(
        .DEPTH     (4),
        .MSB_FIRST (0),
        .PARITY_EN (0)
    ) u_b (
        .clk (clk),
        .rst (rst),
        .bus (ib.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Independent frame model: bit i of a frame.
    function automatic logic exp_bit(
        input logic [2:0] t,
        input logic [7:0] d,
        input bit         msb,
        input int         i
    );
        if (i < 3) begin
            return msb ? t[2-i] : t[i];
        end else if (i < 11) begin
            return msb ? d[7-(i-3)] : d[i-3];
        end
        return ^{t, d};
    endfunction

    // Push one entry into DUT A; called at a negedge.
    task automatic push_a(
        input logic [2:0] t,
        input logic [7:0] d
    );
        fifo_entry_t e;
        e.tag  = t;
        e.data = d;
        ia.in_valid  = 1'b1;
        ia.in_opcode = t;
        ia.in_data   = d;
        if (ia.in_ready) begin
            sbq.push_back(e);
        end
        @(negedge clk);
        ia.in_valid = 1'b0;
    endtask

    // Receive one frame from DUT A against the scoreboard.
    task automatic collect_frame(
        input bit contig,
        input int stall_at,
        input int abort_at
    );
        int          w;
        fifo_entry_t e;
        logic        so;
        logic        sf;
        logic        sl;
        logic        eb;
        w = 0;
        while (!ia.ser_valid && w < 40) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (!ia.ser_valid) begin
            $display("FAIL frame_start: no ser_valid in %0d cycles",
                     w);
            errors++;
            return;
        end
        if (contig) begin
            checks++;
            if (w != 0) begin
                $display("FAIL contiguous: gap=%0d required=0", w);
                errors++;
            end
        end
        checks++;
        if (sbq.size() == 0) begin
            $display("FAIL scoreboard: frame with nothing expected");
            errors++;
            return;
        end
        e = sbq.pop_front();
        for (int i = 0; i < 12; i++) begin
            if (i > 0) begin
                @(negedge clk);
            end
            if (i == abort_at) begin
                checks++;
                if (ia.fifo_count !== 3'd2) begin
                    $display("FAIL pre_reset_count: got=%0d req=2",
                             ia.fifo_count);
                    errors++;
                end
                #2 rst = 1'b1;
                #1;
                checks++;
                if ({ia.ser_valid, ia.fifo_count, ia.in_ready}
                    !== {1'b0, 3'd0, 1'b1}) begin
                    $display("FAIL reset_abort: v=%b cnt=%0d rdy=%b",
                             ia.ser_valid, ia.fifo_count,
                             ia.in_ready);
                    errors++;
                end
                return;
            end
            if (i == stall_at) begin
                so = ia.ser_out;
                sf = ia.ser_first;
                sl = ia.ser_last;
                ia.ser_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    checks++;
                    if ({ia.ser_valid, ia.ser_out, ia.ser_first,
                         ia.ser_last} !== {1'b1, so, sf, sl}) begin
                        $display("FAIL stall_hold: got=%b%b%b%b",
                                 ia.ser_valid, ia.ser_out,
                                 ia.ser_first, ia.ser_last);
                        errors++;
                    end
                end
                ia.ser_ready = 1'b1;
            end
            eb = exp_bit(e.tag, e.data, 1'b1, i);
            checks++;
            if ({ia.ser_valid, ia.ser_out, ia.ser_first,
                 ia.ser_last} !== {1'b1, eb, i == 0, i == 11}) begin
                $display("FAIL bit%0d: vofl got=%b%b%b%b req=1%b%b%b",
                         i, ia.ser_valid, ia.ser_out, ia.ser_first,
                         ia.ser_last, eb, i == 0, i == 11);
                errors++;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ia.in_valid = 1'b0;
        ia.in_data = '0;
        ia.in_opcode = '0;
        ia.ser_ready = 1'b1;
        ib.in_valid = 1'b0;
        ib.in_data = '0;
        ib.in_opcode = '0;
        ib.ser_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({ia.in_ready, ia.ser_valid, ia.ser_out, ia.ser_first,
             ia.ser_last, ia.fifo_count}
            !== {1'b1, 4'b0000, 3'd0}) begin
            $display("FAIL reset_a: rdy=%b v=%b cnt=%0d",
                     ia.in_ready, ia.ser_valid, ia.fifo_count);
            errors++;
        end
        checks++;
        if ({ib.in_ready, ib.ser_valid, ib.ser_out, ib.ser_first,
             ib.ser_last, ib.fifo_count}
            !== {1'b1, 4'b0000, 3'd0}) begin
            $display("FAIL reset_b: rdy=%b v=%b cnt=%0d",
                     ib.in_ready, ib.ser_valid, ib.fifo_count);
            errors++;
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single();
        logic [11:0] bits;
        bits = 12'b1011_0100_1010;
        ia.ser_ready = 1'b1;
        ia.in_valid  = 1'b1;
        ia.in_opcode = OP_ROL;
        ia.in_data   = 8'hA5;
        @(negedge clk);
        ia.in_valid = 1'b0;
        checks++;
        if ({ia.ser_valid, ia.fifo_count} !== {1'b0, 3'd1}) begin
            $display("FAIL single_latency1: v=%b cnt=%0d req v=0 cnt=1",
                     ia.ser_valid, ia.fifo_count);
            errors++;
        end
        @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            if (i > 0) begin
                @(negedge clk);
            end
            checks++;
            if ({ia.ser_valid, ia.ser_out, ia.ser_first,
                 ia.ser_last}
                !== {1'b1, bits[11-i], i == 0, i == 11}) begin
                $display("FAIL single_bit%0d: got=%b%b%b%b req=1%b%b%b",
                         i, ia.ser_valid, ia.ser_out, ia.ser_first,
                         ia.ser_last, bits[11-i], i == 0, i == 11);
                errors++;
            end
        end
        @(negedge clk);
        checks++;
        if (ia.ser_valid !== 1'b0) begin
            $display("FAIL single_end: ser_valid=%b req=0",
                     ia.ser_valid);
            errors++;
        end
    endtask

    task automatic test_back_to_back();
        ia.ser_ready = 1'b1;
        fork
            begin
                for (int k = 0; k < 4; k++) begin
                    push_a(3'($urandom_range(0, 6)),
                           8'($urandom));
                end
            end
            begin
                collect_frame(1'b0, -1, -1);
                repeat (3) collect_frame(1'b1, -1, -1);
            end
        join
        checks++;
        if (ia.ser_valid !== 1'b0 || sbq.size() != 0) begin
            $display("FAIL b2b_end: v=%b left=%0d req v=0 left=0",
                     ia.ser_valid, sbq.size());
            errors++;
        end
    endtask

    task automatic test_full();
        int          acc;
        fifo_entry_t e;
        acc = 0;
        ia.ser_ready = 1'b0;
        ia.in_valid  = 1'b1;
        repeat (8) begin
            e.tag  = 3'($urandom_range(0, 6));
            e.data = 8'($urandom);
            ia.in_opcode = e.tag;
            ia.in_data   = e.data;
            if (ia.in_ready) begin
                sbq.push_back(e);
                acc++;
            end
            @(negedge clk);
        end
        ia.in_valid = 1'b0;
        checks++;
        if (acc != 5) begin
            $display("FAIL full_accepted: got=%0d req=5", acc);
            errors++;
        end
        checks++;
        if ({ia.in_ready, ia.fifo_count} !== {1'b0, 3'd4}) begin
            $display("FAIL full_state: rdy=%b cnt=%0d req rdy=0 cnt=4",
                     ia.in_ready, ia.fifo_count);
            errors++;
        end
        ia.ser_ready = 1'b1;
        collect_frame(1'b0, -1, -1);
        checks++;
        if ({ia.in_ready, ia.fifo_count} !== {1'b1, 3'd3}) begin
            $display("FAIL full_release: rdy=%b cnt=%0d req rdy=1 cnt=3",
                     ia.in_ready, ia.fifo_count);
            errors++;
        end
        repeat (4) collect_frame(1'b1, -1, -1);
        checks++;
        if (sbq.size() != 0 || ia.ser_valid !== 1'b0) begin
            $display("FAIL full_drain: left=%0d v=%b req 0 0",
                     sbq.size(), ia.ser_valid);
            errors++;
        end
    endtask

    task automatic test_stall();
        ia.ser_ready = 1'b1;
        push_a(OP_SRA, 8'h3C);
        collect_frame(1'b0, 5, -1);
        push_a(OP_SLL, 8'hF0);
        collect_frame(1'b0, 5, -1);
    endtask

    task automatic test_reset_mid();
        ia.ser_ready = 1'b1;
        fork
            begin
                push_a(OP_SRL, 8'h5A);
                push_a(OP_SLA, 8'hC3);
                push_a(OP_PASS, 8'h7E);
            end
            collect_frame(1'b0, -1, 7);
        join
        sbq.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (20) begin
            @(negedge clk);
            checks++;
            if ({ia.ser_valid, ia.fifo_count} !== {1'b0, 3'd0}) begin
                $display("FAIL post_reset_idle: v=%b cnt=%0d req 0 0",
                         ia.ser_valid, ia.fifo_count);
                errors++;
            end
        end
        push_a(OP_ROR, 8'h96);
        collect_frame(1'b0, -1, -1);
    endtask

    task automatic test_variant();
        logic [10:0] bits;
        bits = 11'b110_1000_0001;
        ib.ser_ready = 1'b1;
        ib.in_valid  = 1'b1;
        ib.in_opcode = OP_SLA;
        ib.in_data   = 8'h81;
        @(negedge clk);
        ib.in_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 11; i++) begin
            if (i > 0) begin
                @(negedge clk);
            end
            checks++;
            if ({ib.ser_valid, ib.ser_out, ib.ser_first,
                 ib.ser_last}
                !== {1'b1, bits[10-i], i == 0, i == 10}) begin
                $display("FAIL var_bit%0d: got=%b%b%b%b req=1%b%b%b",
                         i, ib.ser_valid, ib.ser_out, ib.ser_first,
                         ib.ser_last, bits[10-i], i == 0, i == 10);
                errors++;
            end
        end
        @(negedge clk);
        checks++;
        if (ib.ser_valid !== 1'b0) begin
            $display("FAIL var_end: ser_valid=%b req=0",
                     ib.ser_valid);
            errors++;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_stall();
        test_reset_mid();
        test_variant();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shift_result_serializer.md
Name: shift_result_serializer

Overview:
Downstream stage of the 8-bit shift/rotate unit. It accepts each 8-bit shift result with its 3-bit opcode tag through a valid/ready handshake and buffers it in a small FIFO. Each entry is emitted as a framed serial bitstream (tag, data, optional even parity) with per-bit valid/ready flow control. It decouples the combinational shift unit from a narrow serial link or test port.

Parameters:
DEPTH, 4, FIFO entries; power of two, minimum 2.
MSB_FIRST, 1, 1 = each field sent MSB first; 0 = LSB first.
PARITY_EN, 1, 1 = append even-parity bit over tag and data; 0 = no parity bit.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  upstream result valid
in_ready  output  1  FIFO can accept an entry
in_data  input  8  shift result
in_opcode  input  3  opcode that produced in_data, sent as the frame tag
ser_out  output  1  current serial bit
ser_valid  output  1  ser_out is valid
ser_ready  input  1  sink accepts the current bit
ser_first  output  1  current bit is the first bit of a frame
ser_last  output  1  current bit is the last bit of a frame
fifo_count  output  $clog2(DEPTH)+1  entries held in the FIFO, excluding the shifter

Behaviour:
- Only clk is used. Reset is asynchronous, active-high. While rst=1: FIFO is emptied, the FSM is in IDLE, and all outputs are 0 except in_ready=1. Asserting rst mid-frame aborts the frame; no partial bits are emitted after reset.
- Push: on a rising edge with in_valid && in_ready, {in_opcode, in_data} is written to the FIFO. in_ready = (fifo_count != DEPTH). There is no pass-through: an empty FIFO still registers the entry.
- Frame: tag[2:0], then data[7:0], then parity if PARITY_EN.
  - FLEN = 11 + PARITY_EN.
  - Each field is ordered by MSB_FIRST. Tag always precedes data.
  - parity = XOR of all 11 tag and data bits, so the count of ones in the frame is even.
- FSM states: IDLE and SHIFT.
  - IDLE: ser_valid=0. If fifo_count != 0, pop the head into the frame shift register, clear the bit counter, and go to SHIFT on the same edge.
  - SHIFT: ser_valid=1 and ser_out = current bit. ser_first = (bitcnt == 0); ser_last = (bitcnt == FLEN-1).
  - A bit transfers on a rising edge with ser_valid && ser_ready. The bit counter then advances and the shift register moves.
  - If ser_ready=0, ser_out, ser_first, ser_last and bitcnt hold stable.
  - On transfer of the last bit: if the FIFO is non-empty, the next entry is popped on the same edge (no bubble) and the FSM stays in SHIFT; otherwise it returns to IDLE.
- Latency: an entry accepted at edge N into an empty, idle block is popped at edge N+1, so its first bit has ser_valid=1 after edge N+1.
- Simultaneous push and pop in one edge are both performed; fifo_count is unchanged.
- Capacity in flight is DEPTH+1: DEPTH entries in the FIFO plus one in the shifter.
- fifo_count and the pointers wrap modulo DEPTH with an extra wrap bit. A push when full or a pop when empty never occurs by construction.
- All outputs are registered or decoded from registered state only. There is no combinational path from in_* or ser_ready to any output.

Decomposition:
- Package shift_pkg holds:
  - opcode constants OP_PASS=3'd0, OP_SLL=3'd1, OP_SRL=3'd2, OP_SLA=3'd3, OP_SRA=3'd4, OP_ROL=3'd5, OP_ROR=3'd6;
  - TAG_W=3 and DATA_W=8;
  - the typedef of the FIFO entry struct {tag, data}.
- One sub-module, sync_fifo, is parameterised by width and depth. It provides push, pop, full, empty and count.
- The serializer FSM, shift register and parity logic stay in the top module.

Test Plan:
- Single frame: MSB_FIRST=1, PARITY_EN=1, ser_ready=1, push opcode=3'b101, data=8'hA5 -> exactly 12 consecutive ser_valid cycles starting 2 cycles after push, bits 1,0,1,1,0,1,0,0,1,0,1,0; ser_first on bit 0, ser_last on bit 11.
- Back-to-back: push 4 entries on consecutive cycles, ser_ready=1 -> 48 contiguous ser_valid cycles with no gap; ser_first every 12 cycles; tags and data in push order.
- Full/backpressure: ser_ready=0, in_valid held high -> 5 entries accepted, then in_ready=0 with fifo_count=4. Raise ser_ready -> in_ready returns to 1 on the cycle after the first frame's last bit transfers.
- Mid-frame stall: drop ser_ready at bit 5 for 3 cycles -> ser_out, ser_first, ser_last hold stable; the frame resumes at bit 5 with no lost or duplicated bit.
- Reset mid-frame: assert rst asynchronously at bit 7 with 2 entries queued -> ser_valid=0, fifo_count=0 and in_ready=1 immediately. After release, no output occurs until a new push.
- Variants: MSB_FIRST=0, PARITY_EN=0, opcode=3'b011, data=8'h81 -> 11 bits 1,1,0,1,0,0,0,0,0,0,1 with ser_last on bit 10.
